ripple_count_monitor: RTL

Synchronous capture-and-check stage downstream of the 3-bit asynchronous ripple up counter. It samples the counter's free-running `q` bus into the system clock domain and filters out ripple glitches by accepting only values seen stable on two consecutive synchronised samples. It then publishes each accepted count with a one-cycle valid pulse, counts wrap-arounds, and can flag skipped counts.

---
 rtl/ripple_count_monitor.sv | 103 ++++++++++
 1 files changed

// File: rtl/ripple_count_monitor.sv
// Synchronises an asynchronous ripple-counter bus, filters ripple glitches and publishes accepted counts.
// Optional skip/backward detection is compiled in when RCM_ERR_CHECK_EN is defined.
module ripple_count_monitor #(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  cnt_in,
  input  logic              clr,
  output logic [WIDTH-1:0]  cnt_out,
  output logic              cnt_valid,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err
);

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_s3;

  logic w_stable;
  logic w_change;
  logic w_backward;

  // A candidate is trusted only once two consecutive synchronised samples agree.
  assign w_stable   = (r_s2 == r_s3);
  assign w_change   = w_stable && (r_s3 != cnt_out);
  assign w_backward = (r_s3 < cnt_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_PRIME;
      r_s1      <= '0;
      r_s2      <= '0;
      r_s3      <= '0;
      cnt_out   <= '0;
      cnt_valid <= 1'b0;
      wrap      <= 1'b0;
      wrap_cnt  <= '0;
    end else begin
      r_s1      <= cnt_in;
      r_s2      <= r_s1;
      r_s3      <= r_s2;
      cnt_valid <= 1'b0;
      wrap      <= 1'b0;
      if (clr) begin
        r_state  <= ST_PRIME;
        wrap_cnt <= '0;
      end else begin
        case (r_state)
          ST_PRIME: begin
            if (w_stable) begin
              cnt_out <= r_s3;
              r_state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (w_change) begin
              cnt_out   <= r_s3;
              cnt_valid <= 1'b1;
              if (w_backward) begin
                wrap <= 1'b1;
                if (wrap_cnt != {WRAP_W{1'b1}}) begin
                  wrap_cnt <= wrap_cnt + WRAP_W'(1);
                end
              end
            end
          end
          default: r_state <= ST_PRIME;
        endcase
      end
    end
  end

`ifdef RCM_ERR_CHECK_EN
  logic [WIDTH-1:0] w_expect;
  logic             w_skip;

  // Any accepted value other than the modular successor means a count was missed or went backward.
  assign w_expect = cnt_out + WIDTH'(1);
  assign w_skip   = (r_s3 != w_expect);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (clr) begin
      err <= 1'b0;
    end else if ((r_state == ST_RUN) && w_change && w_skip) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
